// File: rtl/bootrom_loader_if.sv
// rtl/bootrom_loader_if.sv - ROM read port and destination write channel of the boot ROM loader.
interface bootrom_loader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DST_AW = 32
) ();
    logic              rom_me;
    logic              rom_oe;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic              dst_valid;
    logic              dst_ready;
    logic [DST_AW-1:0] dst_addr;
    logic [DATA_W-1:0] dst_data;

    modport master (
        output rom_me, rom_oe, rom_address, dst_valid, dst_addr, dst_data,
        input  rom_q, dst_ready
    );

    modport slave (
        input  rom_me, rom_oe, rom_address, dst_valid, dst_addr, dst_data,
        output rom_q, dst_ready
    );
endinterface

// File: rtl/bootrom_loader.sv
// rtl/bootrom_loader.sv - copies word_count ROM words to a destination write channel.
// Optional running checksum output enabled by BOOTROM_LOADER_CHECKSUM_EN.
module bootrom_loader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DST_AW = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [DST_AW-1:0]   dst_base,
    input  logic [ADDR_W:0]     word_count,
    bootrom_loader_if.master    mem,
    output logic                busy,
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    output logic                done,
    output logic [DATA_W-1:0]   checksum
`else
    output logic                done
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] SRC_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;
    localparam logic [DST_AW-1:0] DST_STEP = DST_AW'(DATA_W / 8);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [DST_AW-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            // start is only looked at here, so a pulse while busy is dropped.
            S_IDLE: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    cnt_d   = word_count;
                    busy_d  = 1'b1;
                    state_d = (word_count == CNT_ZERO) ? S_FINISH : S_READ;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d  = mem.rom_q;
                valid_d = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem.dst_ready) begin
                    valid_d = 1'b0;
                    src_d   = src_q + SRC_ONE;
                    dst_d   = dst_q + DST_STEP;
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? S_FINISH : S_READ;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + data_q;
`endif
                end
            end
            // done is registered, so it rises in the same cycle busy falls.
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem.rom_me      = (state_q == S_READ);
    assign mem.rom_oe      = busy_q;
    assign mem.rom_address = src_q;
    assign mem.dst_valid   = valid_q;
    assign mem.dst_addr    = dst_q;
    assign mem.dst_data    = data_q;
    assign busy            = busy_q;
    assign done            = done_q;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    assign checksum        = sum_q;
`endif

endmodule

// File: tb/tb_bootrom_loader.sv
// tb/tb_bootrom_loader.sv - table-driven scoreboard bench for bootrom_loader.
module tb_bootrom_loader;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DST_AW = 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [DST_AW-1:0] dst_base = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              busy;
    logic              done;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    always #5 clock = ~clock;

    bootrom_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DST_AW(DST_AW)) mem ();

    bootrom_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DST_AW(DST_AW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .word_count (word_count),
        .mem        (mem),
        .busy       (busy),
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        .done       (done),
        .checksum   (checksum)
`else
        .done       (done)
`endif
    );

    logic [DATA_W-1:0] rom [2048];

    always @(posedge clock) begin
        if (mem.rom_me) mem.rom_q <= rom[mem.rom_address];
    end

    typedef struct {
        logic [DST_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [DST_AW-1:0] dst;
        logic [ADDR_W:0]   cnt;
        int                stall_word;
        int                stall;
        bit                restart;
        int                exp_lat;
    } vec_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] src_exp_q[$];
    vec_t              vecs[7];
    int                n_checks = 0;
    int                n_fail = 0;
    int                stall_word = -1;
    int                stall_left = 0;
    int                words_seen = 0;
    int                done_count = 0;
    logic [DATA_W-1:0] model_sum = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: wait for the falling edge, check outputs, then decide dst_ready for the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clock);
        if (reset_n) begin
            chk("rom_oe_tracks_busy", 64'(mem.rom_oe), 64'(busy));
            if (mem.rom_me) begin
                if (src_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rom_me: got address 0x%0h, want no read", mem.rom_address);
                end else begin
                    chk("rom_address", 64'(mem.rom_address), 64'(src_exp_q.pop_front()));
                end
            end
            if (mem.dst_valid && stall_left > 0 && words_seen == stall_word) begin
                mem.dst_ready = 1'b0;
                stall_left--;
            end else begin
                mem.dst_ready = 1'b1;
            end
            if (mem.dst_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_dst_valid: got addr 0x%0h, want no write", mem.dst_addr);
                end else begin
                    e = exp_q[0];
                    chk("dst_addr", 64'(mem.dst_addr), 64'(e.addr));
                    chk("dst_data", 64'(mem.dst_data), 64'(e.data));
                    if (mem.dst_ready) begin
                        e = exp_q.pop_front();
                        words_seen++;
                    end
                end
            end
            if (done) done_count++;
        end else begin
            mem.dst_ready = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rom_me"}, 64'(mem.rom_me), 64'd0);
        chk({tag, "_rom_oe"}, 64'(mem.rom_oe), 64'd0);
        chk({tag, "_rom_address"}, 64'(mem.rom_address), 64'd0);
        chk({tag, "_dst_valid"}, 64'(mem.dst_valid), 64'd0);
        chk({tag, "_dst_addr"}, 64'(mem.dst_addr), 64'd0);
        chk({tag, "_dst_data"}, 64'(mem.dst_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, 64'(checksum), 64'd0);
`endif
    endtask

    // Push the expected reads and writes, then raise start for the coming rising edge.
    task automatic launch(input vec_t v);
        exp_t              e;
        logic [ADDR_W-1:0] a;
        model_sum = '0;
        for (int k = 0; k < int'(v.cnt); k++) begin
            a = v.src + ADDR_W'(k);
            src_exp_q.push_back(a);
            e.addr = v.dst + DST_AW'(4 * k);
            e.data = rom[a];
            exp_q.push_back(e);
            model_sum = model_sum + rom[a];
        end
        words_seen = 0;
        stall_word = v.stall_word;
        stall_left = v.stall;
        src_base   = v.src;
        dst_base   = v.dst;
        word_count = v.cnt;
        start      = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat = -1;
        int busy_cyc = 0;
        launch(v);
        for (int t = 1; t <= 120 && lat < 0; t++) begin
            step();
            start = 1'b0;
            if (v.restart && t == 5) begin
                src_base   = 11'd7;
                dst_base   = 32'hDEAD_0000;
                word_count = 12'd2;
                start      = 1'b1;
            end
            if (busy) busy_cyc++;
            if (done) lat = t;
        end
        start = 1'b0;
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL vec%0d_done_timeout: got no done in 120 cycles, want done at %0d", idx, v.exp_lat);
        end else begin
            chk($sformatf("vec%0d_done_latency", idx), 64'(lat), 64'(v.exp_lat));
        end
        chk($sformatf("vec%0d_busy_cycles", idx), 64'(busy_cyc), 64'(v.exp_lat - 1));
        chk($sformatf("vec%0d_writes_left", idx), 64'(exp_q.size()), 64'd0);
        chk($sformatf("vec%0d_reads_left", idx), 64'(src_exp_q.size()), 64'd0);
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        chk($sformatf("vec%0d_checksum", idx), 64'(checksum), 64'(model_sum));
        if (v.src == 0 && v.cnt == 4) chk("checksum_first_four", 64'(checksum), 64'h0000_00AA);
`endif
        step();
        chk($sformatf("vec%0d_done_one_cycle", idx), 64'(done), 64'd0);
        chk($sformatf("vec%0d_busy_after", idx), 64'(busy), 64'd0);
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        chk($sformatf("vec%0d_checksum_hold", idx), 64'(checksum), 64'(model_sum));
`endif
        exp_q.delete();
        src_exp_q.delete();
    endtask

    initial begin
        vec_t rv;
        int   dc;
        bit   found;

        for (int i = 0; i < 2048; i++) rom[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;
        rom[3] = 32'h44;

        // src, dst, count, stall word, stall cycles, restart, done latency (3 cycles/word + 2)
        vecs[0] = '{11'd0,    32'h8000_0000, 12'd4, -1, 0, 1'b0, 14};
        vecs[1] = '{11'd0,    32'h0000_0000, 12'd0, -1, 0, 1'b0, 2};
        vecs[2] = '{11'd2046, 32'h0000_0100, 12'd3, -1, 0, 1'b0, 11};
        vecs[3] = '{11'd0,    32'h8000_0000, 12'd4,  1, 5, 1'b0, 19};
        vecs[4] = '{11'd10,   32'h0000_0200, 12'd4, -1, 0, 1'b1, 14};
        vecs[5] = '{11'd5,    32'hFFFF_FFF8, 12'd3, -1, 0, 1'b0, 11};
        vecs[6] = '{11'd100,  32'h0000_0040, 12'd1, -1, 0, 1'b0, 5};

        mem.dst_ready = 1'b1;
        #1;
        check_idle("reset");
        step();
        step();
        reset_n = 1'b1;
        step();
        check_idle("idle");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset while word 2 of 4 is held in WRITE by a low dst_ready.
        rv = '{11'd0, 32'h8000_0000, 12'd4, 1, 40, 1'b0, 14};
        launch(rv);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            step();
            start = 1'b0;
            if (mem.dst_valid && words_seen == 1) found = 1'b1;
        end
        chk("reached_word2_write", 64'(found), 64'd1);
        dc = done_count;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        step();
        step();
        exp_q.delete();
        src_exp_q.delete();
        stall_left = 0;
        reset_n = 1'b1;
        #1;
        check_idle("release");
        step();
        chk("no_done_after_abort", 64'(done_count), 64'(dc));
        run_vec(vecs[0], 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
